// File: rtl/clas_pkg.sv
// Shared constants and types for the beat classifier MAC/argmax engine.
// Optional feature macro: CLAS_BIAS_EN (per-class accumulator bias).
package clas_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FEAT_CNT   = 24;
  localparam int CLASS_CNT  = 4;
  localparam int ACC_WIDTH  = 24;
  localparam int ADDR_WIDTH = 8;
  localparam int WT_CNT     = FEAT_CNT * CLASS_CNT;

  localparam logic [ADDR_WIDTH-1:0] WT_ADDR_CLAS = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    ARGMAX = 2'd2,
    OUT    = 2'd3
  } clas_state_e;

`ifdef CLAS_BIAS_EN
  // Index 0 is the rightmost element.
  localparam logic [CLASS_CNT-1:0][ACC_WIDTH-1:0] CLAS_BIAS = {
    24'sd1000, 24'sd0, 24'sd0, 24'sd0
  };
`endif

endpackage

// File: rtl/clas_argmax.sv
// Combinational 4-way signed max, lowest index wins ties.
// Ports: score_i scores in; idx_o winning index; score_o scores passed through.
module clas_argmax
  import clas_pkg::*;
(
  input  logic [CLASS_CNT-1:0][ACC_WIDTH-1:0] score_i,
  output logic [1:0]                          idx_o,
  output logic [CLASS_CNT-1:0][ACC_WIDTH-1:0] score_o
);

  logic [ACC_WIDTH-1:0] best;

  // Strict greater-than keeps the earlier index on a tie.
  always_comb begin
    idx_o = 2'd0;
    best  = score_i[0];
    for (int i = 1; i < CLASS_CNT; i++) begin
      if ($signed(score_i[i]) > $signed(best)) begin
        best  = score_i[i];
        idx_o = 2'(i);
      end
    end
  end

  assign score_o = score_i;

endmodule

// File: rtl/clas_mac_argmax.sv
// Classifier: 4 parallel MACs over 24 features, then argmax.
// Ports: in_valid/in_ready+feat_i in; wt_addr/wt_i LUT; out_valid/out_ready+class_o/score_o out. Macro CLAS_BIAS_EN.
module clas_mac_argmax
  import clas_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FEAT_CNT-1:0][DATA_WIDTH-1:0]  feat_i,
  output logic [ADDR_WIDTH-1:0]                wt_addr,
  input  logic [WT_CNT-1:0][DATA_WIDTH-1:0]    wt_i,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [1:0]                           class_o,
  output logic [CLASS_CNT-1:0][ACC_WIDTH-1:0]  score_o
);

  clas_state_e                          state;
  logic [FEAT_CNT-1:0][DATA_WIDTH-1:0]  feat_q;
  logic [4:0]                           k;
  logic [CLASS_CNT-1:0][ACC_WIDTH-1:0]  acc;
  logic [CLASS_CNT-1:0][ACC_WIDTH-1:0]  prod;
  logic [CLASS_CNT-1:0][ACC_WIDTH-1:0]  max_sc;
  logic [1:0]                           max_idx;
  logic [ACC_WIDTH-1:0]                 fx;
  logic [ACC_WIDTH-1:0]                 wx;
  logic [6:0]                           widx;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == OUT);
  assign wt_addr   = (state == MAC) ? WT_ADDR_CLAS
                                    : '0;

  // Operands are sign-extended first so the
  // 24-bit product needs no further extension.
  always_comb begin
    prod = '0;
    fx   = ACC_WIDTH'($signed(feat_q[k]));
    wx   = '0;
    widx = '0;
    for (int c = 0; c < CLASS_CNT; c++) begin
      widx    = 7'(c * FEAT_CNT) + 7'(k);
      wx      = ACC_WIDTH'($signed(wt_i[widx]));
      prod[c] = fx * wx;
    end
  end

  clas_argmax u_argmax (
    .score_i (acc),
    .idx_o   (max_idx),
    .score_o (max_sc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      feat_q  <= '0;
      k       <= '0;
      acc     <= '0;
      class_o <= '0;
      score_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            feat_q <= feat_i;
            k      <= '0;
`ifdef CLAS_BIAS_EN
            acc    <= CLAS_BIAS;
`else
            acc    <= '0;
`endif
            state  <= MAC;
          end
        end
        MAC: begin
          for (int c = 0; c < CLASS_CNT; c++)
            acc[c] <= acc[c] + prod[c];
          if (k == 5'(FEAT_CNT - 1)) begin
            k     <= '0;
            state <= ARGMAX;
          end else begin
            k <= k + 5'd1;
          end
        end
        ARGMAX: begin
          class_o <= max_idx;
          score_o <= max_sc;
          state   <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
